// File: rtl/prefetch_pkg.sv
// prefetch_pkg
// Definitions shared by the prefetcher and the TX/RX serial engines: the
// width and encoding of the TX command header, plus a helper that sizes
// the request/credit counters.
package prefetch_pkg;

  localparam int TX_CMD_BITS = 4;

  // Header that asks the memory for one 16-bit word.
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16 = 4'h3;

  // Width of a counter that must hold every value from 0 to depth.
  function automatic int ctr_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prefetcher_deep_if.sv
// prefetcher_deep_if
// Groups the signals between the prefetcher, the decoder and the serial
// engines.
//   master : the prefetcher (drives inst*, tx_command*, tx_data, in_flight)
//   slave  : its environment (decoder, TX engine, RX engine)
// Decoder side : inst, inst_pc, inst_valid, inst_ready, jump, jump_target
// TX side      : tx_command_valid, tx_command, tx_command_started,
//                tx_data, tx_data_next, tx_counter
// RX side      : rx_data_valid, rx_pins, rx_done
// Status       : in_flight
interface prefetcher_deep_if
  import prefetch_pkg::*;
#(
  parameter int IO_BITS        = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int DEPTH          = 4
) ();
  localparam int INST_BITS = IO_BITS * PAYLOAD_CYCLES;
  localparam int CW        = ctr_bits(DEPTH);
  localparam int TCW       = $clog2(PAYLOAD_CYCLES);

  logic [INST_BITS-1:0]   inst;
  logic [INST_BITS-1:0]   inst_pc;
  logic                   inst_valid;
  logic                   inst_ready;
  logic                   jump;
  logic [INST_BITS-1:0]   jump_target;
  logic                   tx_command_valid;
  logic [TX_CMD_BITS-1:0] tx_command;
  logic                   tx_command_started;
  logic [IO_BITS-1:0]     tx_data;
  logic                   tx_data_next;
  logic [TCW-1:0]         tx_counter;
  logic                   rx_data_valid;
  logic [IO_BITS-1:0]     rx_pins;
  logic                   rx_done;
  logic [CW-1:0]          in_flight;

  modport master (
    output inst, inst_pc, inst_valid, tx_command_valid, tx_command,
           tx_data, in_flight,
    input  inst_ready, jump, jump_target, tx_command_started, tx_data_next,
           tx_counter, rx_data_valid, rx_pins, rx_done
  );

  modport slave (
    input  inst, inst_pc, inst_valid, tx_command_valid, tx_command,
           tx_data, in_flight,
    output inst_ready, jump, jump_target, tx_command_started, tx_data_next,
           tx_counter, rx_data_valid, rx_pins, rx_done
  );

endinterface

// File: rtl/prefetcher_deep_sync_fifo.sv
// sync_fifo
// Small first-word-fall-through queue used to hold fetched {pc, word}
// entries. The head entry is presented combinationally on o_data.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_push, i_data  : write an entry (ignored when full or flushing)
//   i_pop           : drop the head entry (ignored when empty or flushing)
//   i_flush         : discard every entry this cycle
//   o_data          : head entry
//   o_empty, o_full : status flags
//   o_count         : number of stored entries
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int BITS  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [BITS-1:0]            i_data,
  output logic [BITS-1:0]            o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/prefetcher_deep.sv
// prefetcher_deep
// Instruction prefetcher for the serial memory bus. Issues READ_16
// commands whenever credit allows, serialises the latched request address
// LSB-first, assembles replies into words and queues them with their fetch
// address for the decoder. A jump redirects fetching and discards every
// reply that was already requested.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : prefetcher_deep_if.master (decoder, TX engine, RX engine)
module prefetcher_deep
  import prefetch_pkg::*;
#(
  parameter int IO_BITS        = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int DEPTH          = 4,
  parameter int PC_STEP        = 2,
  parameter logic [IO_BITS*PAYLOAD_CYCLES-1:0] RESET_PC = 16'hfffc
) (
  input logic              clk,
  input logic              reset,
  prefetcher_deep_if.master bus
);
  localparam int INST_BITS  = IO_BITS * PAYLOAD_CYCLES;
  localparam int PC_BITS    = INST_BITS;
  localparam int CW         = ctr_bits(DEPTH);
  localparam int ENTRY_BITS = PC_BITS + INST_BITS;

  logic [PC_BITS-1:0]    r_fetch_pc;
  logic [PC_BITS-1:0]    r_tx_addr;
  logic [PC_BITS-1:0]    r_resp_pc;
  logic [CW-1:0]         r_in_flight;
  logic [CW-1:0]         r_discard;
  logic [INST_BITS-1:0]  r_sreg;

  logic [CW-1:0]         w_in_flight_next;
  logic [CW-1:0]         w_occ;
  logic [INST_BITS-1:0]  w_sreg_next;
  logic [ENTRY_BITS-1:0] w_head;
  logic                  w_start;
  logic                  w_done;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [IO_BITS-1:0]    w_slice [PAYLOAD_CYCLES];

  assign w_start = bus.tx_command_started;
  assign w_done  = bus.rx_done;

  // The word being completed includes the beat arriving this cycle.
  assign w_sreg_next = {bus.rx_pins, r_sreg[INST_BITS-1:IO_BITS]};

  assign w_in_flight_next = r_in_flight + CW'(w_start) - CW'(w_done);

  // A reply is kept only when nothing older is owed to a jump, and never
  // in a jump cycle (the jump already counted it in w_in_flight_next).
  assign w_push = w_done && (r_discard == '0) && !bus.jump;
  assign w_pop  = !w_empty && bus.inst_ready && !bus.jump;

  sync_fifo #(
    .DEPTH (DEPTH),
    .BITS  (ENTRY_BITS)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.jump),
    .i_data  ({r_resp_pc, w_sreg_next}),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_occ)
  );

  // Address slices for each payload beat, LSB slice first.
  for (genvar gi = 0; gi < PAYLOAD_CYCLES; gi++) begin : g_slice
    assign w_slice[gi] = r_tx_addr[gi*IO_BITS +: IO_BITS];
  end

  assign bus.tx_data    = w_slice[bus.tx_counter];
  assign bus.tx_command = TX_HEADER_READ_16;

  // Credit: every issued request must have a guaranteed queue slot, so
  // outstanding requests plus queued words may not exceed DEPTH.
  assign bus.tx_command_valid =
    ({1'b0, r_in_flight} + {1'b0, w_occ}) < (CW + 1)'(DEPTH);

  assign bus.inst       = w_head[INST_BITS-1:0];
  assign bus.inst_pc    = w_head[ENTRY_BITS-1:INST_BITS];
  assign bus.inst_valid = !w_empty;
  assign bus.in_flight  = r_in_flight;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_tx_addr   <= RESET_PC;
      r_resp_pc   <= RESET_PC;
      r_in_flight <= '0;
      r_discard   <= '0;
      r_sreg      <= '0;
    end else begin
      r_in_flight <= w_in_flight_next;
      if (bus.rx_data_valid) r_sreg <= w_sreg_next;

      // A command started in a jump cycle still transmits the old address;
      // its reply is covered by the discard count below.
      if (w_start) r_tx_addr <= r_fetch_pc;

      if (bus.jump) begin
        r_fetch_pc <= bus.jump_target;
        r_resp_pc  <= bus.jump_target;
        r_discard  <= w_in_flight_next;
      end else begin
        if (w_start) r_fetch_pc <= r_fetch_pc + PC_BITS'(PC_STEP);
        if (w_done && (r_discard != '0)) r_discard <= r_discard - CW'(1);
        if (w_push) r_resp_pc <= r_resp_pc + PC_BITS'(PC_STEP);
      end
    end
  end

  // The credit rule makes a push into a full queue impossible, and a TX
  // payload beat always belongs to a request that has not yet returned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && w_full));
      assert (!bus.tx_data_next || (r_in_flight != '0));
    end
  end

endmodule

// File: tb/tb_prefetcher_deep.sv
module tb_prefetcher_deep;
  import prefetch_pkg::*;

  localparam int IO_BITS        = 2;
  localparam int PAYLOAD_CYCLES = 8;
  localparam int DEPTH          = 4;
  localparam int PC_STEP        = 2;
  localparam int W              = IO_BITS * PAYLOAD_CYCLES;
  localparam int TCW            = $clog2(PAYLOAD_CYCLES);
  localparam logic [W-1:0] RESET_PC = 16'hfffc;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prefetcher_deep_if #(
    .IO_BITS(IO_BITS), .PAYLOAD_CYCLES(PAYLOAD_CYCLES), .DEPTH(DEPTH)
  ) bus ();

  prefetcher_deep #(
    .IO_BITS(IO_BITS), .PAYLOAD_CYCLES(PAYLOAD_CYCLES), .DEPTH(DEPTH),
    .PC_STEP(PC_STEP), .RESET_PC(RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: every request ever issued is remembered in order with
  // its address; a jump marks everything outstanding as stale. Replies come
  // back in request order, stale ones vanish, the rest join the queue.
  typedef struct {
    logic [W-1:0] addr;
    bit           stale;
  } req_t;

  req_t           out_q[$];
  logic [2*W-1:0] mq[$];
  logic [W-1:0]   m_fetch_pc;
  logic [W-1:0]   m_tx_addr;

  // Serial engine emulation.
  bit           tx_busy;
  int           tx_beat;
  logic [W-1:0] tx_asm;
  logic [W-1:0] tx_last_word;
  bit           rx_busy;
  int           rx_beat;
  int           rx_avail;
  logic [W-1:0] rx_word;
  logic [W-1:0] rx_words_q[$];
  int           n_started = 0;
  int           n_done    = 0;

  task automatic drive_idle();
    bus.inst_ready         = 1'b0;
    bus.jump               = 1'b0;
    bus.jump_target        = '0;
    bus.tx_command_started = 1'b0;
    bus.tx_data_next       = 1'b0;
    bus.tx_counter         = '0;
    bus.rx_data_valid      = 1'b0;
    bus.rx_pins            = '0;
    bus.rx_done            = 1'b0;
  endtask

  task automatic model_clear();
    out_q.delete();
    mq.delete();
    rx_words_q.delete();
    m_fetch_pc = RESET_PC;
    m_tx_addr  = RESET_PC;
    tx_busy    = 1'b0;
    tx_beat    = 0;
    rx_busy    = 1'b0;
    rx_beat    = 0;
    rx_avail   = 0;
  endtask

  task automatic do_reset();
    logic [W-1:0] rpc;
    rpc = RESET_PC;
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    model_clear();
    @(posedge clk);
    #1;
    check_eq("rst_inst_valid", bus.inst_valid, 0);
    check_eq("rst_in_flight", bus.in_flight, 0);
    check_eq("rst_cmd_valid", bus.tx_command_valid, 1);
    check_eq("rst_tx_data", bus.tx_data, rpc[IO_BITS-1:0]);
    reset = 1'b0;
  endtask

  // One clock cycle: check registered outputs against the model, drive the
  // engines and decoder, then advance the model to the post-edge state.
  task automatic cycle(input bit want_start, input bit want_rx, input bit ready,
                       input bit do_jump, input logic [W-1:0] target);
    bit   exp_cv, do_start, do_rx, done, pop, keep;
    int   cnt;
    req_t r;
    @(negedge clk);
    check_eq("inst_valid", bus.inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("inst_pc", bus.inst_pc, mq[0][2*W-1:W]);
      check_eq("inst", bus.inst, mq[0][W-1:0]);
    end
    check_eq("in_flight", bus.in_flight, out_q.size());
    exp_cv = (out_q.size() + mq.size()) < DEPTH;
    check_eq("cmd_valid", bus.tx_command_valid, exp_cv);
    check_eq("tx_command", bus.tx_command, TX_HEADER_READ_16);

    do_start = want_start && !tx_busy && exp_cv;
    bus.tx_command_started = do_start;
    cnt = tx_busy ? tx_beat : int'($urandom_range(0, PAYLOAD_CYCLES - 1));
    bus.tx_data_next = tx_busy;
    bus.tx_counter   = TCW'(cnt);

    do_rx = want_rx && (rx_busy || rx_avail > 0);
    if (do_rx && !rx_busy) begin
      rx_busy = 1'b1;
      rx_beat = 0;
      rx_avail--;
      if (rx_words_q.size() != 0) rx_word = rx_words_q.pop_front();
      else                        rx_word = W'($urandom);
    end
    done = do_rx && (rx_beat == PAYLOAD_CYCLES - 1);
    bus.rx_data_valid = do_rx;
    bus.rx_pins       = do_rx ? rx_word[rx_beat*IO_BITS +: IO_BITS] : IO_BITS'($urandom);
    bus.rx_done       = done;
    bus.inst_ready    = ready;
    bus.jump          = do_jump;
    bus.jump_target   = target;
    #1;
    check_eq("tx_data", bus.tx_data, m_tx_addr[cnt*IO_BITS +: IO_BITS]);
    if (tx_busy) tx_asm[tx_beat*IO_BITS +: IO_BITS] = bus.tx_data;

    pop  = (mq.size() != 0) && ready;
    keep = 1'b0;
    if (done && out_q.size() != 0) begin
      r    = out_q.pop_front();
      keep = !r.stale && !do_jump;
    end
    if (tx_busy) begin
      tx_beat++;
      if (tx_beat == PAYLOAD_CYCLES) begin
        tx_busy      = 1'b0;
        rx_avail++;
        tx_last_word = tx_asm;
      end
    end
    if (do_start) begin
      out_q.push_back('{addr: m_fetch_pc, stale: do_jump});
      m_tx_addr  = m_fetch_pc;
      m_fetch_pc = m_fetch_pc + W'(PC_STEP);
      tx_busy    = 1'b1;
      tx_beat    = 0;
      n_started++;
    end
    if (do_rx) begin
      rx_beat++;
      if (done) begin
        rx_busy = 1'b0;
        n_done++;
      end
    end
    if (do_jump) begin
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      mq.delete();
      m_fetch_pc = target;
    end else begin
      if (pop)  mq.delete(0);
      if (keep) mq.push_back({r.addr, rx_word});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_n(input int n, input bit ready);
    int base;
    base = n_started;
    for (int k = 0; k < 40 * n + 40 && n_started < base + n; k++) cycle(1'b1, 1'b0, ready, 1'b0, '0);
    check_eq("start_budget", n_started - base, n);
    for (int k = 0; k < 20 && tx_busy; k++) cycle(1'b0, 1'b0, ready, 1'b0, '0);
  endtask

  task automatic reply_n(input int n, input bit ready);
    int base;
    base = n_done;
    for (int k = 0; k < 40 * n + 40 && n_done < base + n; k++) cycle(1'b0, 1'b1, ready, 1'b0, '0);
    check_eq("reply_budget", n_done - base, n);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && mq.size() != 0; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_clear();
    do_reset();

    // Reset and issue: first request spells RESET_PC, credit runs out at 4.
    start_n(1, 1'b0);
    check_eq("first_req_addr", tx_last_word, 16'hfffc);
    start_n(3, 1'b0);
    check_eq("cmd_valid_after4", bus.tx_command_valid, 0);
    check_eq("in_flight_after4", bus.in_flight, 4);

    // Ordered delivery.
    rx_words_q.push_back(16'h1234);
    rx_words_q.push_back(16'h5678);
    reply_n(1, 1'b0);
    check_eq("first_word_valid", bus.inst_valid, 1);
    check_eq("first_word_pc", bus.inst_pc, 16'hfffc);
    check_eq("first_word", bus.inst, 16'h1234);
    reply_n(1, 1'b0);
    check_eq("head_pc_kept", bus.inst_pc, 16'hfffc);
    check_eq("in_flight_2", bus.in_flight, 2);

    // Backpressure: full queue holds credit at zero until one pop.
    reply_n(2, 1'b0);
    check_eq("full_cmd_valid", bus.tx_command_valid, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_eq("pop_restores_credit", bus.tx_command_valid, 1);
    check_eq("pop_next_head", bus.inst_pc, 16'hfffe);
    drain();

    // Jump with three requests in flight.
    start_n(3, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100);
    check_eq("post_jump_credit", bus.tx_command_valid, 1);
    reply_n(3, 1'b0);
    check_eq("stale_dropped", bus.inst_valid, 0);
    start_n(1, 1'b0);
    reply_n(1, 1'b0);
    check_eq("jump_first_pc", bus.inst_pc, 16'h0100);
    check_eq("jump_first_valid", bus.inst_valid, 1);
    drain();

    // Same-cycle jump, reply completion, pop and command start.
    start_n(2, 1'b0);
    reply_n(1, 1'b0);
    for (int k = 0; k < 40 && !(rx_busy && rx_beat == PAYLOAD_CYCLES - 1); k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0200);
    check_eq("conflict_queue_empty", bus.inst_valid, 0);
    check_eq("conflict_in_flight", bus.in_flight, 1);
    for (int k = 0; k < 20 && tx_busy; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    reply_n(1, 1'b0);
    check_eq("conflict_stale_dropped", bus.inst_valid, 0);
    start_n(1, 1'b0);
    reply_n(1, 1'b0);
    check_eq("conflict_first_pc", bus.inst_pc, 16'h0200);

    // Address wrap, then reset in the middle of a payload.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'hfffe);
    start_n(1, 1'b0);
    check_eq("wrap_req0", tx_last_word, 16'hfffe);
    start_n(1, 1'b0);
    check_eq("wrap_req1", tx_last_word, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    do_reset();

    // Randomised traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, W'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
